// File: rtl/rv_pkg.sv
// Shared constants and payload type for the RV32 instruction-fetch path.
package rv_pkg;

    localparam int unsigned DEF_ADDR_WIDTH = 32;
    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned PC_STEP        = 4;
    localparam logic [31:0] RV_NOP         = 32'h0000_0013;

    typedef struct packed {
        logic [DEF_ADDR_WIDTH-1:0] pc;
        logic [DEF_DATA_WIDTH-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fq_fifo.sv
// Generic first-word-fall-through FIFO with flush; the head word is visible
// on rdata in the same cycle it becomes valid.
module fq_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + PW'(1);
            if (pop)  head <= head + PW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst && !flush && push) mem[tail] <= wdata;
    end

    assign rdata = mem[head];

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch stage: owns the PC, drives a combinational-read imem and
// buffers {pc, instr} pairs for decode; a redirect flushes and restarts fetch.
module fetch_queue
    import rv_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int unsigned           ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int unsigned           DEPTH        = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR    = DATA_WIDTH'(RV_NOP)
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic [ADDR_WIDTH-1:0]      imem_addr,
    output logic                       imem_en,
    input  logic [DATA_WIDTH-1:0]      imem_rdata,
    input  logic                       redirect,
    input  logic [ADDR_WIDTH-1:0]      redirect_target,
    output logic                       if_valid,
    input  logic                       if_ready,
    output logic [DATA_WIDTH-1:0]      if_instr,
    output logic [ADDR_WIDTH-1:0]      if_pc,
    output logic [ADDR_WIDTH-1:0]      if_pc_plus4,
    output logic [$clog2(DEPTH+1)-1:0] q_count
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned EW = ADDR_WIDTH + DATA_WIDTH;

    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [ADDR_WIDTH-1:0] last_pc;
    logic [ADDR_WIDTH-1:0] head_pc;
    logic [DATA_WIDTH-1:0] head_instr;
    logic [EW-1:0]         head_entry;
    logic [CW-1:0]         count;
    logic                  valid;
    logic                  pop;
    logic                  push;
    logic                  fifo_pop;

    // A full queue may still fetch when decode drains the head this cycle.
    assign valid    = rst && (count != '0);
    assign pop      = valid && if_ready;
    assign push     = rst && !redirect && ((count < CW'(DEPTH)) || pop);
    assign fifo_pop = pop && !redirect;

    assign imem_addr = fetch_pc;
    assign imem_en   = push;

    fq_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (fifo_pop),
        .flush (redirect),
        .wdata ({fetch_pc, imem_rdata}),
        .rdata (head_entry),
        .count (count)
    );

    assign head_pc    = head_entry[EW-1 -: ADDR_WIDTH];
    assign head_instr = head_entry[DATA_WIDTH-1:0];

    // last_pc lets if_pc hold its previous value while the queue is empty.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc <= RESET_VECTOR;
            last_pc  <= '0;
        end else begin
            last_pc <= if_pc;
            if (redirect)  fetch_pc <= redirect_target & ~ADDR_WIDTH'(3);
            else if (push) fetch_pc <= fetch_pc + ADDR_WIDTH'(PC_STEP);
        end
    end

    assign if_valid    = valid;
    assign if_pc       = !rst ? '0 : (valid ? head_pc : last_pc);
    assign if_instr    = valid ? head_instr : NOP_INSTR;
    assign if_pc_plus4 = if_pc + ADDR_WIDTH'(PC_STEP);
    assign q_count     = rst ? count : '0;

endmodule
